// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: op encoding, FSM states, lane widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lsu_pkg;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_LH  = 3'b001,
      OP_LHU = 3'b010,
      OP_LB  = 3'b011,
      OP_LBU = 3'b100,
      OP_SW  = 3'b101,
      OP_SH  = 3'b110,
      OP_SB  = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_MRG,
      S_WR
   } state_e;

   function automatic logic is_store(op_e o);
      return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and data-memory signals of the load/store unit.
// Latency: n/a (signal bundle).
// Backpressure: requester must hold req until busy=0; memory side has fixed one-cycle read latency.
// slave  : LSU view (takes req/op/addr/wdata/mem_rdata, drives status, result and memory strobes)
// master : pipeline + memory view (the opposite directions)
interface load_store_unit_if;
   logic        req;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        misaligned;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;

   modport slave (
      input  req, op, addr, wdata, mem_rdata,
      output busy, done, rdata, misaligned, mem_addr, mem_wdata, mem_read, mem_write
   );

   modport master (
      output req, op, addr, wdata, mem_rdata,
      input  busy, done, rdata, misaligned, mem_addr, mem_wdata, mem_read, mem_write
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane extract/extend for loads and lane merge for sub-word stores (little-endian).
// Latency: purely combinational.
// Backpressure: none.
// Ports: op_i (access type), off_i (byte offset in word), word_i (memory word),
//        sdata_i (store data low half), load_o (extended load value), merge_o (word with lane replaced)
module lsu_lane_align
   import lsu_pkg::*;
(
   input  op_e                 op_i,
   input  logic [1:0]          off_i,
   input  logic [WORD_W-1:0]   word_i,
   input  logic [HALF_W-1:0]   sdata_i,
   output logic [WORD_W-1:0]   load_o,
   output logic [WORD_W-1:0]   merge_o
);

   logic [BYTE_W-1:0] byte_sel;
   logic [HALF_W-1:0] half_sel;

   always_comb begin
      // Halfword lane picks on off_i[1] only, so an odd halfword offset is ignored here.
      byte_sel = word_i[{off_i, 3'b000} +: BYTE_W];
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

      load_o  = word_i;
      merge_o = word_i;

      case (op_i)
         OP_LH:   load_o = {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
         OP_LHU:  load_o = {{(WORD_W-HALF_W){1'b0}}, half_sel};
         OP_LB:   load_o = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
         OP_LBU:  load_o = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
         default: load_o = word_i;
      endcase

      case (op_i)
         OP_SB: merge_o[{off_i, 3'b000} +: BYTE_W] = sdata_i[BYTE_W-1:0];
         OP_SH: begin
            if (off_i[1]) merge_o[31:16] = sdata_i;
            else          merge_o[15:0]  = sdata_i;
         end
         default: merge_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: word loads/stores, sub-word loads with extension, sub-word stores by read-merge-write.
// Latency: done 3 cycles after accept for loads, 2 for SW, 4 for SB/SH (1 for a rejected misaligned access).
// Backpressure: busy=1 blocks new requests; done is issued in IDLE so a held req is taken with no bubble.
// Ports: clk, reset (async active-high), bus (load_store_unit_if.slave: request side and data-memory side).
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned word/halfword accesses with misaligned=1.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   load_store_unit_if.slave  bus
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [1:0]        off_q, off_d;
   logic [HALF_W-1:0] sdata_q, sdata_d;
   logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              mis_q, mis_d;

   op_e               op_in;
   logic              misalign_in;
   logic [WORD_W-1:0] load_ext;
   logic [WORD_W-1:0] merged;

   assign op_in = op_e'(bus.op);

`ifdef LSU_ALIGN_CHECK_EN
   always_comb begin
      case (op_in)
         OP_LW, OP_SW:         misalign_in = (bus.addr[1:0] != 2'b00);
         OP_LH, OP_LHU, OP_SH: misalign_in = bus.addr[0];
         default:              misalign_in = 1'b0;
      endcase
   end
`else
   assign misalign_in = 1'b0;
`endif

   // Lane logic works on the registered op/offset so input changes after accept have no effect.
   lsu_lane_align u_lane (
      .op_i    (op_q),
      .off_i   (off_q),
      .word_i  (bus.mem_rdata),
      .sdata_i (sdata_q),
      .load_o  (load_ext),
      .merge_o (merged)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_LW;
         off_q       <= 2'b00;
         sdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         mis_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         off_q       <= off_d;
         sdata_q     <= sdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         mis_q       <= mis_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      off_d       = off_q;
      sdata_d     = sdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      mis_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               op_d       = op_in;
               off_d      = bus.addr[1:0];
               sdata_d    = bus.wdata[HALF_W-1:0];
               mem_addr_d = {bus.addr[31:2], 2'b00};
               if (misalign_in) begin
                  // Rejected access completes from IDLE without touching memory or rdata.
                  done_d = 1'b1;
                  mis_d  = 1'b1;
               end else if (op_in == OP_SW) begin
                  mem_wdata_d = bus.wdata;
                  state_d     = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD:  state_d = is_store(op_q) ? S_MRG : S_CAP;
         S_CAP: begin
            rdata_d = load_ext;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_MRG: begin
            mem_wdata_d = merged;
            state_d     = S_WR;
         end
         S_WR: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.mem_read   = (state_q == S_RD);
   assign bus.mem_write  = (state_q == S_WR);
   assign bus.done       = done_q;
   assign bus.misaligned = mis_q;
   assign bus.rdata      = rdata_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous word RAM model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_load_store_unit;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   load_store_unit_if bus ();

   load_store_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Synchronous word RAM: read data registered one cycle after mem_read, write at the edge.
   logic [31:0] mem [64];
   always @(posedge clk) begin
      if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[7:2]];
      if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
   end

   // Issues one request from an aligned point (just after a rising edge, unit idle) and
   // follows it to done. Inputs are scrambled right after accept to show they are captured.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                        output int lat, output int rd, output int wr,
                        output logic [31:0] rdat, output logic mis, output int both);
      lat = 0; rd = 0; wr = 0; both = 0; rdat = '0; mis = 1'b0;
      bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = w;
      @(posedge clk); #1;
      bus.req = 1'b0; bus.op = 3'b011; bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'h5555_5555;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         rd   += int'(bus.mem_read);
         wr   += int'(bus.mem_write);
         both += int'(bus.mem_read && bus.mem_write);
         if (bus.done) begin
            lat  = i;
            rdat = bus.rdata;
            mis  = bus.misaligned;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req = 1'b0; bus.op = 3'b000; bus.addr = '0; bus.wdata = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
      n_checks++; if (bus.misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis got %b want 0", bus.misaligned); end
      n_checks++; if (bus.rdata !== 32'h0)    begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
      n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
      n_checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0)
         begin n_fail++; $display("FAIL reset_strobes got rd=%b wr=%b want 0 0", bus.mem_read, bus.mem_write); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_sw_lw();
      int lat, rd, wr, both; logic [31:0] rdat; logic mis;
      do_op(3'b101, 32'h10, 32'hDEAD_BEEF, lat, rd, wr, rdat, mis, both);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", lat); end
      n_checks++; if (wr !== 1 || rd !== 0) begin n_fail++; $display("FAIL sw_strobes got rd=%0d wr=%0d want 0 1", rd, wr); end
      n_checks++; if (mem[4] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_word got %h want deadbeef", mem[4]); end
      n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL sw_mem_addr got %h want 00000010", bus.mem_addr); end
      do_op(3'b000, 32'h10, 32'h0, lat, rd, wr, rdat, mis, both);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency got %0d want 3", lat); end
      n_checks++; if (rdat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata got %h want deadbeef", rdat); end
      n_checks++; if (rd !== 1 || wr !== 0) begin n_fail++; $display("FAIL lw_strobes got rd=%0d wr=%0d want 1 0", rd, wr); end
   endtask

   task automatic test_loads();
      int lat, rd, wr, both; logic [31:0] rdat; logic mis;
      logic [2:0]  ops  [8] = '{3'b011, 3'b100, 3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
      logic [31:0] adrs [8] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h11, 32'h12, 32'h10};
      logic [31:0] exps [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'hFFFF_80FF,
                                32'h0000_80FF, 32'h0000_007F, 32'h0000_00FF, 32'h80FF_7F01};
      do_op(3'b101, 32'h10, 32'h80FF_7F01, lat, rd, wr, rdat, mis, both);
      for (int i = 0; i < 8; i++) begin
         do_op(ops[i], adrs[i], 32'h0, lat, rd, wr, rdat, mis, both);
         n_checks++;
         if (rdat !== exps[i] || lat !== 3 || both !== 0)
            begin n_fail++; $display("FAIL load_%0d got rdata=%h lat=%0d want rdata=%h lat=3", i, rdat, lat, exps[i]); end
      end
   endtask

   task automatic test_sub_store();
      int lat, rd, wr, both; logic [31:0] rdat; logic mis;
      do_op(3'b101, 32'h10, 32'h1122_3344, lat, rd, wr, rdat, mis, both);
      do_op(3'b111, 32'h11, 32'h0000_00AA, lat, rd, wr, rdat, mis, both);
      n_checks++; if (mem[4] !== 32'h1122_AA44) begin n_fail++; $display("FAIL sb_word got %h want 1122aa44", mem[4]); end
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL sb_latency got %0d want 4", lat); end
      n_checks++; if (wr !== 1 || rd !== 1 || both !== 0)
         begin n_fail++; $display("FAIL sb_strobes got rd=%0d wr=%0d want 1 1", rd, wr); end
      n_checks++; if (rdat !== 32'h80FF_7F01) begin n_fail++; $display("FAIL sb_rdata_held got %h want 80ff7f01", rdat); end
      do_op(3'b110, 32'h12, 32'h1234_BEEF, lat, rd, wr, rdat, mis, both);
      n_checks++; if (mem[4] !== 32'hBEEF_AA44) begin n_fail++; $display("FAIL sh_word got %h want beefaa44", mem[4]); end
      do_op(3'b111, 32'h13, 32'hFFFF_FF77, lat, rd, wr, rdat, mis, both);
      n_checks++; if (mem[4] !== 32'h77EF_AA44) begin n_fail++; $display("FAIL sb_hi_word got %h want 77efaa44", mem[4]); end
   endtask

   task automatic test_align();
      int lat, rd, wr, both; logic [31:0] rdat; logic mis;
`ifdef LSU_ALIGN_CHECK_EN
      do_op(3'b001, 32'h11, 32'h0, lat, rd, wr, rdat, mis, both);
      n_checks++; if (lat !== 1 || mis !== 1'b1)
         begin n_fail++; $display("FAIL mis_lh got lat=%0d mis=%b want 1 1", lat, mis); end
      n_checks++; if (rd !== 0 || rdat !== 32'h80FF_7F01)
         begin n_fail++; $display("FAIL mis_lh_side got rd=%0d rdata=%h want 0 80ff7f01", rd, rdat); end
      do_op(3'b101, 32'h12, 32'h0, lat, rd, wr, rdat, mis, both);
      n_checks++; if (lat !== 1 || mis !== 1'b1 || wr !== 0 || mem[4] !== 32'h77EF_AA44)
         begin n_fail++; $display("FAIL mis_sw got lat=%0d mis=%b wr=%0d word=%h want 1 1 0 77efaa44", lat, mis, wr, mem[4]); end
      do_op(3'b100, 32'h11, 32'h0, lat, rd, wr, rdat, mis, both);
      n_checks++; if (rdat !== 32'h0000_00AA || mis !== 1'b0)
         begin n_fail++; $display("FAIL lbu_odd got rdata=%h mis=%b want 000000aa 0", rdat, mis); end
`else
      do_op(3'b001, 32'h11, 32'h0, lat, rd, wr, rdat, mis, both);
      n_checks++; if (rdat !== 32'hFFFF_AA44 || lat !== 3)
         begin n_fail++; $display("FAIL lh_odd got rdata=%h lat=%0d want ffffaa44 3", rdat, lat); end
      n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL lh_odd_mis got %b want 0", mis); end
      do_op(3'b000, 32'h13, 32'h0, lat, rd, wr, rdat, mis, both);
      n_checks++; if (rdat !== 32'h77EF_AA44) begin n_fail++; $display("FAIL lw_odd got %h want 77efaa44", rdat); end
`endif
   endtask

   task automatic test_reset_mid();
      int lat, rd, wr, both, dn; logic [31:0] rdat; logic mis;
      do_op(3'b101, 32'h10, 32'h1122_3344, lat, rd, wr, rdat, mis, both);
      bus.req = 1'b1; bus.op = 3'b111; bus.addr = 32'h11; bus.wdata = 32'hAA;
      @(posedge clk); #1;           // accepted, RD cycle
      bus.req = 1'b0;
      @(posedge clk); #1;           // MRG cycle
      reset = 1'b1;
      #1;
      n_checks++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.busy !== 1'b0)
         begin n_fail++; $display("FAIL rst_mid_now got wr=%b rd=%b busy=%b want 0 0 0", bus.mem_write, bus.mem_read, bus.busy); end
      @(posedge clk); #1;
      reset = 1'b0;
      wr = 0; dn = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         wr += int'(bus.mem_write);
         dn += int'(bus.done);
      end
      n_checks++; if (wr !== 0 || dn !== 0) begin n_fail++; $display("FAIL rst_mid_after got wr=%0d done=%0d want 0 0", wr, dn); end
      n_checks++; if (mem[4] !== 32'h1122_3344) begin n_fail++; $display("FAIL rst_mid_word got %h want 11223344", mem[4]); end
      n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata got %h want 0", bus.rdata); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      bus.req = 1'b1; bus.op = 3'b101; bus.addr = 32'h20; bus.wdata = 32'hA5A5_0001;
      @(posedge clk); #1;           // first accepted
      bus.addr = 32'h24; bus.wdata = 32'h5A5A_0002;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy1 got %b want 1", bus.busy); end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0)
         begin n_fail++; $display("FAIL b2b_done1 got done=%b busy=%b want 1 0", bus.done, bus.busy); end
      @(posedge clk); #1;           // second accepted in the done cycle
      bus.req = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1 || bus.mem_write !== 1'b1)
         begin n_fail++; $display("FAIL b2b_second got busy=%b wr=%b want 1 1", bus.busy, bus.mem_write); end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 got %b want 1", bus.done); end
      @(posedge clk); #1;
      n_checks++; if (mem[8] !== 32'hA5A5_0001 || mem[9] !== 32'h5A5A_0002)
         begin n_fail++; $display("FAIL b2b_words got %h %h want a5a50001 5a5a0002", mem[8], mem[9]); end
   endtask

   initial begin
      test_reset();
      test_sw_lw();
      test_loads();
      test_sub_store();
      test_align();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  async active-high; forces IDLE and all outputs to reset values.
REQ-004 req  input  1  pipeline request valid; accepted only at a rising edge where busy=0.
REQ-005 op  input  3  LW=000 LH=001 LHU=010 LB=011 LBU=100 SW=101 SH=110 SB=111.
REQ-006 addr  input  32  byte address of the access.
REQ-007 wdata  input  32  store data; SB uses [7:0], SH uses [15:0].
REQ-008 busy  output  1  high while state != IDLE.
REQ-009 done  output  1  one-cycle pulse marking completion of an accepted request.
REQ-010 rdata  output  32  registered load result, extended per op; valid when done=1 for a load.
REQ-011 misaligned  output  1  one-cycle pulse, coincident with done, flagging an aborted access.
REQ-012 mem_addr  output  32  word address {addr[31:2],2'b00}, held for the whole operation.
REQ-013 mem_wdata  output  32  registered word to write.
REQ-014 mem_read, mem_write  output  1 each  memory strobes, decoded from state; never both high.
REQ-015 mem_rdata  input  32  word from data memory, valid the cycle after a mem_read cycle.

Function
REQ-016 Byte lanes SHALL be little-endian: byte k = bits [8k+7:8k], k=addr[1:0]; halfword h = bits [16h+15:16h], h=addr[1].
REQ-017 FSM states: IDLE, RD, CAP, MRG, WR.
REQ-018 Load: IDLE -accept-> RD (mem_read=1) -> CAP (capture and extend mem_rdata into rdata) -> IDLE with done=1; done occurs in the 3rd cycle after the accept edge.
REQ-019 SW: IDLE -accept-> WR (mem_write=1, mem_wdata=wdata) -> IDLE with done=1 (2nd cycle after accept).
REQ-020 SB/SH: IDLE -> RD (mem_read=1) -> MRG (replace the selected lane of mem_rdata with the store data, register it into mem_wdata) -> WR (mem_write=1) -> IDLE with done=1 (4th cycle after accept).
REQ-021 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW passes the word unchanged.
REQ-022 rdata SHALL hold its value until the next completed load; stores do not alter rdata.
REQ-023 op, addr and wdata SHALL be registered at accept; later input changes SHALL NOT affect the operation in flight.
REQ-024 done SHALL be asserted in IDLE with busy=0, so a new req is accepted in the done cycle (back-to-back issue, no bubble).
REQ-025 mem_write SHALL be high for exactly one cycle per store; mem_read exactly one cycle per load or sub-word store.

Reset
REQ-026 Reset SHALL force state=IDLE, busy=0, done=0, misaligned=0, rdata=0, mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0.
REQ-027 Reset asserted mid-operation SHALL drop mem_read/mem_write immediately, abort the request without done, and issue no later memory write.

Configuration
REQ-028 Macro LSU_ALIGN_CHECK_EN defined: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0, SHALL issue no memory strobe, and SHALL pulse done=1 and misaligned=1 in the cycle after accept, with rdata unchanged.
REQ-029 LSU_ALIGN_CHECK_EN undefined: misaligned SHALL be tied 0; word ops ignore addr[1:0]; halfword ops ignore addr[0].

Structure
REQ-030 Package lsu_pkg SHALL hold the op encoding enum, the FSM state enum and the lane-width constants.
REQ-031 The combinational lane extract/extend/merge logic SHALL be a single sub-module, lsu_lane_align.

Verification
REQ-032 Bench SHALL model the memory as a synchronous word RAM: registered read one cycle after mem_read, write at the clock edge.
REQ-033 SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> rdata=0xDEADBEEF with done in the 3rd cycle after accept.
REQ-034 Word 0x80FF7F01 at 0x10: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x10 -> 0x00007F01; LH 0x12 -> 0xFFFF80FF.
REQ-035 Word 0x11223344 at 0x10: SB addr=0x11 wdata=0xAA -> word 0x1122AA44; mem_write high exactly one cycle; done in the 4th cycle after accept.
REQ-036 With LSU_ALIGN_CHECK_EN: LH 0x11 -> done=1 and misaligned=1 in the next cycle, mem_read never high, rdata unchanged.
REQ-037 Reset asserted in the MRG cycle of SB 0x11 -> mem_write stays 0 and the word stays 0x11223344; req held high across two SWs -> the second is accepted in the first's done cycle.
